// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller.
// Holds the request op codes, the ALU fn / LogicFn encodings, the decoded
// control bundle and the controller FSM state enum.
package alu_ctrl_pkg;

    // Request op codes accepted on req_op
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;

    // ALU result-select (fn) encodings
    localparam logic [1:0] FN_ARITH = 2'b00;
    localparam logic [1:0] FN_LOGIC = 2'b01;

    // ALU LogicFn encodings
    localparam logic [1:0] LF_AND = 2'b00;
    localparam logic [1:0] LF_OR  = 2'b01;
    localparam logic [1:0] LF_XOR = 2'b10;
    localparam logic [1:0] LF_NOR = 2'b11;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op-code decoder for the ALU controller.
// Ports:
//   op       in  4  request op code
//   add_sub  out 1  1 = subtract (arith ops only)
//   logicfn  out 2  ALU LogicFn select (logic ops only)
//   fn       out 2  ALU result select
//   is_logic out 1  op is a logic op (overflow is meaningless)
//   illegal  out 1  op is not a recognised code
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] op,
    output logic       add_sub,
    output logic [1:0] logicfn,
    output logic [1:0] fn,
    output logic       is_logic,
    output logic       illegal
);

    // Map op code to ALU controls; anything unlisted is flagged illegal
    always_comb begin
        add_sub  = 1'b0;
        logicfn  = LF_AND;
        fn       = FN_ARITH;
        is_logic = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_ADD: begin
                fn      = FN_ARITH;
                add_sub = 1'b0;
            end
            OP_SUB: begin
                fn      = FN_ARITH;
                add_sub = 1'b1;
            end
            OP_AND: begin
                fn       = FN_LOGIC;
                logicfn  = LF_AND;
                is_logic = 1'b1;
            end
            OP_OR: begin
                fn       = FN_LOGIC;
                logicfn  = LF_OR;
                is_logic = 1'b1;
            end
            OP_XOR: begin
                fn       = FN_LOGIC;
                logicfn  = LF_XOR;
                is_logic = 1'b1;
            end
            OP_NOR: begin
                fn       = FN_LOGIC;
                logicfn  = LF_NOR;
                is_logic = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing controller for an external combinational ALU.
// Accepts one request at a time (valid/ready), holds the decoded ALU controls
// and operands in registers for EXEC_CYCLES cycles, captures the ALU result
// and overflow, and presents them on a valid/ready response port.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_op, req_a, req_b        request op code and operands
//   alu_x, alu_y                operands to the ALU
//   alu_add_sub, alu_logicfn,   ALU control
//   alu_fn
//   alu_result, alu_overflow    ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_ovf,          captured result, overflow, illegal-op flag
//   rsp_illegal
//   ovf_sticky, ovf_clr         sticky overflow flag and its synchronous clear
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_add_sub,
    output logic [1:0]       alu_logicfn,
    output logic [1:0]       alu_fn,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             rsp_illegal,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_e           state_r;
    state_e           state_s;
    logic [3:0]       cnt_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             add_sub_r;
    logic [1:0]       logicfn_r;
    logic [1:0]       fn_r;
    logic             is_logic_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_ovf_r;
    logic             rsp_illegal_r;
    logic             rsp_valid_r;
    logic             req_ready_r;
    logic             ovf_sticky_r;

    logic             dec_add_sub_s;
    logic [1:0]       dec_logicfn_s;
    logic [1:0]       dec_fn_s;
    logic             dec_is_logic_s;
    logic             dec_illegal_s;
    logic             accept_s;
    logic             capture_s;
    logic             rsp_done_s;
    logic             ovf_set_s;

    alu_op_decode u_decode (
        .op       (req_op),
        .add_sub  (dec_add_sub_s),
        .logicfn  (dec_logicfn_s),
        .fn       (dec_fn_s),
        .is_logic (dec_is_logic_s),
        .illegal  (dec_illegal_s)
    );

    // req_ready_r already implies IDLE once out of reset; the state term keeps
    // the accept decode self-contained.
    assign accept_s   = req_valid && req_ready_r && (state_r == ST_IDLE);
    assign capture_s  = (state_r == ST_EXEC) && (cnt_r == 4'd0);
    assign rsp_done_s = (state_r == ST_RESP) && rsp_valid_r && rsp_ready;
    assign ovf_set_s  = capture_s && !is_logic_r && alu_overflow;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (dec_illegal_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (capture_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered handshake flags. An illegal op enters RESP straight from IDLE
    // but presents its response one cycle later, so its latency is one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP) && (state_r != ST_IDLE);
        end
    end

    // Execution cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (accept_s && !dec_illegal_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_EXEC) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // ALU operand/control registers; only a legal request updates them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r        <= '0;
            y_r        <= '0;
            add_sub_r  <= 1'b0;
            logicfn_r  <= 2'b00;
            fn_r       <= 2'b00;
            is_logic_r <= 1'b0;
        end else if (accept_s && !dec_illegal_s) begin
            x_r        <= req_a;
            y_r        <= req_b;
            add_sub_r  <= dec_add_sub_s;
            logicfn_r  <= dec_logicfn_s;
            fn_r       <= dec_fn_s;
            is_logic_r <= dec_is_logic_s;
        end else begin
            x_r        <= x_r;
            y_r        <= y_r;
            add_sub_r  <= add_sub_r;
            logicfn_r  <= logicfn_r;
            fn_r       <= fn_r;
            is_logic_r <= is_logic_r;
        end
    end

    // Response capture; logic ops never report overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r    <= '0;
            rsp_ovf_r     <= 1'b0;
            rsp_illegal_r <= 1'b0;
        end else if (accept_s && dec_illegal_s) begin
            rsp_data_r    <= '0;
            rsp_ovf_r     <= 1'b0;
            rsp_illegal_r <= 1'b1;
        end else if (capture_s) begin
            rsp_data_r    <= alu_result;
            rsp_ovf_r     <= is_logic_r ? 1'b0 : alu_overflow;
            rsp_illegal_r <= 1'b0;
        end else begin
            rsp_data_r    <= rsp_data_r;
            rsp_ovf_r     <= rsp_ovf_r;
            rsp_illegal_r <= rsp_illegal_r;
        end
    end

    // Sticky overflow; a set on the capture edge beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_sticky_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_r <= 1'b0;
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

    assign req_ready   = req_ready_r;
    assign alu_x       = x_r;
    assign alu_y       = y_r;
    assign alu_add_sub = add_sub_r;
    assign alu_logicfn = logicfn_r;
    assign alu_fn      = fn_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_ovf     = rsp_ovf_r;
    assign rsp_illegal = rsp_illegal_r;
    assign ovf_sticky  = ovf_sticky_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: a behavioural ALU sits on the alu_* ports,
// and expected responses come from a plain-arithmetic reference of the op table.
module tb_alu_ctrl;

    localparam int W  = 32;
    localparam int EC = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [W-1:0] alu_x;
    logic [W-1:0] alu_y;
    logic         alu_add_sub;
    logic [1:0]   alu_logicfn;
    logic [1:0]   alu_fn;
    logic [W-1:0] alu_result;
    logic         alu_overflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;
    logic         rsp_illegal;
    logic         ovf_sticky;
    logic         ovf_clr;

    // Overflow value the bench ALU reports for logic ops (garbage the DUT must mask)
    logic         junk_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic         exp_sticky;
    logic [W-1:0] last_x;
    logic [W-1:0] last_y;
    logic [4:0]   last_ctl;

    alu_ctrl #(.WIDTH(W), .EXEC_CYCLES(EC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_add_sub  (alu_add_sub),
        .alu_logicfn  (alu_logicfn),
        .alu_fn       (alu_fn),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_ovf      (rsp_ovf),
        .rsp_illegal  (rsp_illegal),
        .ovf_sticky   (ovf_sticky),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU driven by the controller outputs
    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        if (alu_fn == 2'b00) begin
            if (alu_add_sub) begin
                alu_result   = alu_x - alu_y;
                alu_overflow = (alu_x[31] != alu_y[31]) && (alu_result[31] != alu_x[31]);
            end else begin
                alu_result   = alu_x + alu_y;
                alu_overflow = (alu_x[31] == alu_y[31]) && (alu_result[31] != alu_x[31]);
            end
        end else if (alu_fn == 2'b01) begin
            case (alu_logicfn)
                2'b00:   alu_result = alu_x & alu_y;
                2'b01:   alu_result = alu_x | alu_y;
                2'b10:   alu_result = alu_x ^ alu_y;
                default: alu_result = ~(alu_x | alu_y);
            endcase
            alu_overflow = junk_ovf;
        end else begin
            alu_result   = 32'd0;
            alu_overflow = 1'b0;
        end
    end

    // Watchdog: every wait below is a fixed cycle count, this only guards the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic op_legal(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op >= 4'd4 && op <= 4'd7);
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Signed overflow from true integer arithmetic
    function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint s;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 4'd0) s = sa + sb;
        else if (op == 4'd1) s = sa - sb;
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Expected {fn, logicfn, add_sub} for a legal op
    function automatic logic [4:0] ref_ctl(input logic [3:0] op);
        case (op)
            4'd0:    return {2'b00, 2'b00, 1'b0};
            4'd1:    return {2'b00, 2'b00, 1'b1};
            4'd4:    return {2'b01, 2'b00, 1'b0};
            4'd5:    return {2'b01, 2'b01, 1'b0};
            4'd6:    return {2'b01, 2'b10, 1'b0};
            default: return {2'b01, 2'b11, 1'b0};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: accept, execute, hold response, handshake
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic junk, input int hold, input logic clr_cap, input string tag);
        logic         legal;
        int           lat;
        logic [31:0]  ed;
        logic         eo;
        logic [31:0]  ex;
        logic [31:0]  ey;
        logic [4:0]   ectl;
        legal = op_legal(op);
        lat   = legal ? EC : 1;
        ed    = legal ? ref_result(op, a, b) : 32'd0;
        eo    = legal ? ref_ovf(op, a, b) : 1'b0;
        ex    = legal ? a : last_x;
        ey    = legal ? b : last_y;
        ectl  = legal ? ref_ctl(op) : last_ctl;
        junk_ovf = junk;

        chk({31'd0, req_ready}, 32'd1, {tag, " ready_before"});
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        // Scramble request inputs while busy; they must be ignored
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        for (int k = 0; k < lat; k++) begin
            chk({31'd0, rsp_valid}, 32'd0, {tag, " early_valid"});
            chk({31'd0, req_ready}, 32'd0, {tag, " busy_ready"});
            chk(alu_x, ex, {tag, " alu_x"});
            chk(alu_y, ey, {tag, " alu_y"});
            chk({27'd0, alu_fn, alu_logicfn, alu_add_sub}, {27'd0, ectl}, {tag, " alu_ctl"});
            if (k == lat - 1) ovf_clr = clr_cap;
            tick();
        end
        ovf_clr = 1'b0;
        if (legal && eo) exp_sticky = 1'b1;
        else if (clr_cap) exp_sticky = 1'b0;

        for (int h = 0; h <= hold; h++) begin
            chk({31'd0, rsp_valid}, 32'd1, {tag, " rsp_valid"});
            chk(rsp_data, ed, {tag, " rsp_data"});
            chk({31'd0, rsp_ovf}, {31'd0, eo}, {tag, " rsp_ovf"});
            chk({31'd0, rsp_illegal}, {31'd0, ~legal}, {tag, " rsp_illegal"});
            chk({31'd0, req_ready}, 32'd0, {tag, " resp_ready"});
            chk({31'd0, ovf_sticky}, {31'd0, exp_sticky}, {tag, " sticky"});
            chk(alu_x, ex, {tag, " alu_x_resp"});
            if (h == hold) rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({31'd0, rsp_valid}, 32'd0, {tag, " valid_after_hs"});
        chk({31'd0, req_ready}, 32'd1, {tag, " ready_after_hs"});
        chk({31'd0, ovf_sticky}, {31'd0, exp_sticky}, {tag, " sticky_after_hs"});
        if (legal) begin
            last_x   = a;
            last_y   = b;
            last_ctl = ectl;
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  legal_ops [6];
        legal_ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 4'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        rsp_ready  = 1'b0;
        ovf_clr    = 1'b0;
        junk_ovf   = 1'b0;
        exp_sticky = 1'b0;
        last_x     = 32'd0;
        last_y     = 32'd0;
        last_ctl   = 5'd0;

        // Reset state
        #12;
        chk({31'd0, req_ready}, 32'd0, "rst ready");
        chk({31'd0, rsp_valid}, 32'd0, "rst valid");
        chk(rsp_data, 32'd0, "rst data");
        chk(alu_x, 32'd0, "rst alu_x");
        chk({31'd0, ovf_sticky}, 32'd0, "rst sticky");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({31'd0, req_ready}, 32'd0, "release ready_before_clk");
        tick();
        chk({31'd0, req_ready}, 32'd1, "release ready_after_clk");

        // Directed cases
        do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, "add_ovf");
        ovf_clr = 1'b1;
        tick();
        ovf_clr    = 1'b0;
        exp_sticky = 1'b0;
        chk({31'd0, ovf_sticky}, 32'd0, "idle_clear sticky");
        do_op(4'd1, 32'd5, 32'd7, 1'b0, 0, 1'b0, "sub");
        do_op(4'd6, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1, 0, 1'b0, "xor_forced_ovf");
        do_op(4'hF, $urandom, $urandom, 1'b0, 0, 1'b0, "illegal_f");
        do_op(4'd4, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 5, 1'b0, "and_hold5");
        do_op(4'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1, 1'b1, "set_wins");
        do_op(4'd0, 32'd1, 32'd2, 1'b0, 0, 1'b1, "clr_no_ovf");
        do_op(4'd1, 32'h8000_0000, 32'd1, 1'b0, 2, 1'b0, "sub_ovf");

        // Reset in EXEC discards the operation
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_a     = 32'h7FFF_FFFF;
        req_b     = 32'h7FFF_FFFF;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        exp_sticky = 1'b0;
        last_x     = 32'd0;
        last_y     = 32'd0;
        last_ctl   = 5'd0;
        chk({31'd0, rsp_valid}, 32'd0, "midrst valid");
        chk({31'd0, req_ready}, 32'd0, "midrst ready");
        chk(alu_x, 32'd0, "midrst alu_x");
        chk({27'd0, alu_fn, alu_logicfn, alu_add_sub}, 32'd0, "midrst alu_ctl");
        chk({31'd0, ovf_sticky}, 32'd0, "midrst sticky");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < EC + 2; k++) begin
            tick();
            chk({31'd0, rsp_valid}, 32'd0, "postrst no_rsp");
            chk({31'd0, req_ready}, 32'd1, "postrst idle");
        end

        // Randomized transactions
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 7) rop = legal_ops[$urandom_range(0, 5)];
            else rop = 4'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h7FFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = 32'h8000_0000;
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%h", i, rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
